// File: rtl/cache_refill_ctrl_if.sv
// Bundle between the direct-mapped cache/CPU and the refill controller.
// The master side is the cache/CPU; the slave side is the controller.
interface cache_refill_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             req;
   logic [31:0]      add;
   logic             miss_i;
   logic             dirty_i;
   logic [127:0]     writeback;
   logic [5:0]       wadd;
   logic             update;
   logic [127:0]     d;
   logic             stall;
   logic             busy;
   logic [CNT_W-1:0] miss_cnt;
   logic [CNT_W-1:0] wb_cnt;

   modport master (
      output req, add, miss_i, dirty_i, writeback, wadd,
      input  update, d, stall, busy, miss_cnt, wb_cnt
   );

   modport slave (
      input  req, add, miss_i, dirty_i, writeback, wadd,
      output update, d, stall, busy, miss_cnt, wb_cnt
   );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Refill controller: writes back a dirty victim and fetches the missed line
// from a behavioural 64-line backing store, then pulses update with the line.
module cache_refill_ctrl #(
   parameter int MEM_LAT = 4,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   cache_refill_ctrl_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WB   = 2'd1,
      S_FILL = 2'd2,
      S_UPD  = 2'd3
   } state_t;

   localparam logic [3:0]       LAT_M1  = 4'(MEM_LAT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t           r_state;
   state_t           w_next;
   logic [3:0]       r_cnt;
   logic [5:0]       r_line;
   logic [5:0]       r_wadd;
   logic [127:0]     r_wb;
   logic [127:0]     r_d;
   logic             r_update;
   logic [CNT_W-1:0] r_miss_cnt;
   logic [CNT_W-1:0] r_wb_cnt;
   logic [127:0]     r_mem [0:63];
   logic [63:0]      r_written;

   logic             w_start;
   logic             w_cnt_zero;
   logic             w_commit;
   logic             w_capture;
   logic [127:0]     w_fill_data;
   logic             w_unused_add;

   // Power-on content of a line: word j of line i is i*4+j, word 0 in the MSBs.
   function automatic logic [127:0] init_line(input logic [5:0] line);
      logic [31:0] base;
      base = {24'd0, line, 2'b00};
      return {base, base + 32'd1, base + 32'd2, base + 32'd3};
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

   assign w_start      = bus.req & bus.miss_i;
   assign w_cnt_zero   = (r_cnt == 4'd0);
   assign w_unused_add = ^{bus.add[31:8], bus.add[1:0]};
   // Lines never written back still hold their power-on pattern.
   assign w_fill_data  = r_written[r_line] ? r_mem[r_line] : init_line(r_line);

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state decode plus the writeback-commit and line-capture strobes.
   always_comb begin
      w_next    = r_state;
      w_commit  = 1'b0;
      w_capture = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_start) begin
               if (bus.dirty_i) begin
                  w_next = S_WB;
               end else begin
                  w_next = S_FILL;
               end
            end else begin
               w_next = S_IDLE;
            end
         end
         S_WB: begin
            if (w_cnt_zero) begin
               w_next   = S_FILL;
               w_commit = 1'b1;
            end else begin
               w_next = S_WB;
            end
         end
         S_FILL: begin
            if (w_cnt_zero) begin
               w_next    = S_UPD;
               w_capture = 1'b1;
            end else begin
               w_next = S_FILL;
            end
         end
         S_UPD:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Latency counter, latched request context, refill data and statistics.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt      <= 4'd0;
         r_line     <= 6'd0;
         r_wadd     <= 6'd0;
         r_wb       <= 128'd0;
         r_d        <= 128'd0;
         r_update   <= 1'b0;
         r_miss_cnt <= '0;
         r_wb_cnt   <= '0;
      end else begin
         r_update <= w_capture;
         if (w_capture) begin
            r_d <= w_fill_data;
         end
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_line     <= bus.add[7:2];
                  r_cnt      <= LAT_M1;
                  r_miss_cnt <= sat_inc(r_miss_cnt);
                  if (bus.dirty_i) begin
                     r_wb   <= bus.writeback;
                     r_wadd <= bus.wadd;
                  end
               end
            end
            S_WB: begin
               if (w_cnt_zero) begin
                  r_cnt    <= LAT_M1;
                  r_wb_cnt <= sat_inc(r_wb_cnt);
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_FILL: begin
               if (!w_cnt_zero) begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            default: begin
               r_cnt <= r_cnt;
            end
         endcase
      end
   end

   // Backing store is not touched by reset; a writeback commits only at WB exit.
   always_ff @(posedge clk) begin
      if (w_commit) begin
         r_mem[r_wadd]     <= r_wb;
         r_written[r_wadd] <= 1'b1;
      end
   end

   assign bus.update   = r_update;
   assign bus.d        = r_d;
   assign bus.busy     = (r_state != S_IDLE);
   assign bus.stall    = (r_state != S_IDLE) | w_start;
   assign bus.miss_cnt = r_miss_cnt;
   assign bus.wb_cnt   = r_wb_cnt;
endmodule
